// File: rtl/fifo_stream_rd.sv
// fifo_stream_rd: converts a fixed-latency FIFO read port into a valid/ready stream with a per-packet beat counter.
// Define FIFO_STREAM_RD_STATS_EN to add saturating stall/starve cycle counters.
module fifo_stream_rd #(
  parameter  int WIDTH  = 16,
  parameter  int RDLAT  = 2,
  parameter  int PKTLEN = 64,
  localparam int BUFD   = RDLAT + 1,
  localparam int CWIDTH = $clog2(PKTLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_q,
  output logic              fifo_read,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_valid,
  output logic              o_last,
  input  logic              o_ready,
  output logic [CWIDTH-1:0] o_beat
`ifdef FIFO_STREAM_RD_STATS_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_starve_cnt
`endif
);

  localparam int PW = $clog2(BUFD);
  localparam int OW = $clog2(BUFD + 1);
  localparam logic [CWIDTH-1:0] LAST_BEAT = CWIDTH'(PKTLEN - 1);
  localparam logic [OW:0]       CREDITS   = (OW + 1)'(BUFD);
  localparam logic [PW-1:0]     PTR_MAX   = PW'(BUFD - 1);

  logic [RDLAT-1:0]  r_pipe;
  logic [RDLAT:0]    w_pipe_ext;
  logic [WIDTH-1:0]  r_buf [BUFD];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [OW-1:0]     r_occ;
  logic [OW-1:0]     w_inflight;
  logic [OW:0]       w_used;
  logic              w_read;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [CWIDTH-1:0] r_beat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_MAX) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Credit check: words buffered plus words still travelling through the FIFO read latency.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RDLAT; i++) begin
      w_inflight = w_inflight + OW'(r_pipe[i]);
    end
    w_used     = {1'b0, r_occ} + {1'b0, w_inflight};
    w_read     = !fifo_empty && (w_used < CREDITS) && !rst;
    w_pipe_ext = {r_pipe, w_read};
    w_valid    = (r_occ != '0);
    w_push     = r_pipe[RDLAT-1];
    w_pop      = w_valid && o_ready;
  end

  // Read-latency pipe and first-word-fall-through skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < BUFD; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_pipe <= w_pipe_ext[RDLAT-1:0];
      if (w_push) begin
        r_buf[r_wr_ptr] <= fifo_q;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Beat index within the packet, wrapping after the last beat is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
    end else if (w_pop) begin
      if (r_beat == LAST_BEAT) begin
        r_beat <= '0;
      end else begin
        r_beat <= r_beat + CWIDTH'(1);
      end
    end else begin
      r_beat <= r_beat;
    end
  end

  assign fifo_read = w_read;
  assign o_valid   = w_valid;
  assign o_data    = r_buf[r_rd_ptr];
  assign o_last    = w_valid && (r_beat == LAST_BEAT);
  assign o_beat    = r_beat;

`ifdef FIFO_STREAM_RD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_starve_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  // Stall = word offered but refused; starve = no word while a packet is partly sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= 32'd0;
      r_starve_cnt <= 32'd0;
    end else begin
      if (w_valid && !o_ready) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if (!w_valid && (r_beat != '0)) begin
        r_starve_cnt <= sat_inc(r_starve_cnt);
      end
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_starve_cnt = r_starve_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Self-checking bench for fifo_stream_rd: behavioural RDLAT=2 FIFO model, directed vector table and corner sequences.
module tb_fifo_stream_rd;
  localparam int W  = 16;
  localparam int RL = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic         o_ready;
  logic [W-1:0] fifo_q;
  logic         rd4, rd8, rd1;
  logic [W-1:0] d4, d8, d1;
  logic         v4, v8, v1, l4, l8, l1;
  logic [2:0]   b4;
  logic [3:0]   b8;
  logic [0:0]   b1;
`ifdef FIFO_STREAM_RD_STATS_EN
  logic [31:0]  st4, sv4, st8, sv8, st1, sv1;
  logic [31:0]  s_stall4, s_starve4, s_starve1;
`endif

  always #5 clk = ~clk;

  fifo_stream_rd #(.WIDTH(W), .RDLAT(RL), .PKTLEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_read(rd4),
    .o_data(d4), .o_valid(v4), .o_last(l4), .o_ready(o_ready), .o_beat(b4)
`ifdef FIFO_STREAM_RD_STATS_EN
    , .o_stall_cnt(st4), .o_starve_cnt(sv4)
`endif
  );
  fifo_stream_rd #(.WIDTH(W), .RDLAT(RL), .PKTLEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_read(rd8),
    .o_data(d8), .o_valid(v8), .o_last(l8), .o_ready(o_ready), .o_beat(b8)
`ifdef FIFO_STREAM_RD_STATS_EN
    , .o_stall_cnt(st8), .o_starve_cnt(sv8)
`endif
  );
  fifo_stream_rd #(.WIDTH(W), .RDLAT(RL), .PKTLEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_read(rd1),
    .o_data(d1), .o_valid(v1), .o_last(l1), .o_ready(o_ready), .o_beat(b1)
`ifdef FIFO_STREAM_RD_STATS_EN
    , .o_stall_cnt(st1), .o_starve_cnt(sv1)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mq1, mq2, next_word;
  int           outstanding, delivered, mb4, mb8, beat_idx;
  logic [15:0]  last_mask4, last_mask8;
  logic         p_stall, p_last;
  logic [W-1:0] p_data;
  logic         s_rd, s_valid, s_last4;
  logic [W-1:0] s_data;
  logic [2:0]   s_beat4;
  logic [3:0]   s_beat8;

  typedef struct {
    int          push;
    logic        rdy;
    logic        rd;
    logic        valid;
    logic [15:0] data;
    logic [2:0]  beat;
    logic        last;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, sample/check at negedge+1, advance FIFO model after posedge.
  task automatic cycle(input logic rdy, input int npush, input logic rst_v);
    logic [W-1:0] w;
    @(negedge clk);
    o_ready = rdy;
    rst     = rst_v;
    for (int i = 0; i < npush; i++) begin
      fq.push_back(next_word);
      exp_q.push_back(next_word);
      next_word = next_word + 16'd1;
    end
    fifo_empty = (fq.size() == 0);
    #1;
    s_rd = rd4; s_valid = v4; s_data = d4; s_last4 = l4; s_beat4 = b4; s_beat8 = b8;
`ifdef FIFO_STREAM_RD_STATS_EN
    s_stall4 = st4; s_starve4 = sv4; s_starve1 = sv1;
`endif
    if (rst_v) begin
      chk("rd_in_rst", 32'(rd4), 32'd0);
    end else begin
      if (rd4) begin
        chk("rd_not_empty", 32'(fifo_empty), 32'd0);
        chk("credit", 32'(outstanding < 3), 32'd1);
      end
      if (p_stall) begin
        chk("hold_valid", 32'(v4), 32'd1);
        chk("hold_data", 32'(d4), 32'(p_data));
        chk("hold_last", 32'(l4), 32'(p_last));
      end
      chk("beat4", 32'(b4), 32'(mb4));
      chk("beat8", 32'(b8), 32'(mb8));
      chk("last4", 32'(l4), 32'(v4 && (mb4 == 3)));
      chk("last8", 32'(l8), 32'(v8 && (mb8 == 7)));
      chk("last1", 32'(l1), 32'(v1));
      if (v4 && rdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(d4), 32'hDEAD);
        end else begin
          w = exp_q.pop_front();
          chk("data4", 32'(d4), 32'(w));
          chk("data8", 32'(d8), 32'(w));
          chk("data1", 32'(d1), 32'(w));
        end
        if (l4 && beat_idx < 16) last_mask4[beat_idx] = 1'b1;
        if (l8 && beat_idx < 16) last_mask8[beat_idx] = 1'b1;
        mb4 = (mb4 + 1) % 4;
        mb8 = (mb8 + 1) % 8;
        beat_idx++;
        delivered++;
        outstanding--;
      end
      if (rd4) outstanding++;
    end
    p_stall = v4 && !rdy && !rst_v;
    p_data  = d4;
    p_last  = l4;
    @(posedge clk);
    #1;
    if (rst_v) begin
      fq.delete(); exp_q.delete();
      mq1 = '0; mq2 = '0;
      outstanding = 0; delivered = 0; mb4 = 0; mb8 = 0; beat_idx = 0;
      last_mask4 = '0; last_mask8 = '0; p_stall = 1'b0;
    end else begin
      mq2 = mq1;
      if (s_rd && fq.size() > 0) mq1 = fq.pop_front();
    end
    fifo_q     = mq2;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b1);
  endtask

  task automatic run_until(input int target, input int maxc);
    for (int c = 0; c < maxc && delivered < target; c++) cycle(1'b1, 0, 1'b0);
    chk("delivered", 32'(delivered), 32'(target));
  endtask

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; o_ready = 1'b0; fifo_empty = 1'b1; fifo_q = '0;
    mq1 = '0; mq2 = '0; next_word = 16'h0001;
    outstanding = 0; delivered = 0; mb4 = 0; mb8 = 0; beat_idx = 0;
    last_mask4 = '0; last_mask8 = '0; p_stall = 1'b0; p_last = 1'b0; p_data = '0;

    // Reset state
    do_reset();
    cycle(1'b1, 0, 1'b0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_last", 32'(s_last4), 32'd0);
    chk("rst_data", 32'(s_data), 32'd0);
    chk("rst_beat", 32'(s_beat4), 32'd0);
    chk("rst_read", 32'(s_rd), 32'd0);

    // Test 1: 8 words pushed at once, o_ready held high
    tbl[0]  = '{8, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[1]  = '{0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[2]  = '{0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[3]  = '{0, 1'b1, 1'b0, 1'b1, 16'h0001, 3'd0, 1'b0};
    tbl[4]  = '{0, 1'b1, 1'b1, 1'b1, 16'h0002, 3'd1, 1'b0};
    tbl[5]  = '{0, 1'b1, 1'b1, 1'b1, 16'h0003, 3'd2, 1'b0};
    tbl[6]  = '{0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd3, 1'b0};
    tbl[7]  = '{0, 1'b1, 1'b0, 1'b1, 16'h0004, 3'd3, 1'b1};
    tbl[8]  = '{0, 1'b1, 1'b1, 1'b1, 16'h0005, 3'd0, 1'b0};
    tbl[9]  = '{0, 1'b1, 1'b1, 1'b1, 16'h0006, 3'd1, 1'b0};
    tbl[10] = '{0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0};
    tbl[11] = '{0, 1'b1, 1'b0, 1'b1, 16'h0007, 3'd2, 1'b0};
    tbl[12] = '{0, 1'b1, 1'b0, 1'b1, 16'h0008, 3'd3, 1'b1};
    tbl[13] = '{0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
    do_reset();
    next_word = 16'h0001;
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].rdy, tbl[i].push, 1'b0);
      chk("t1_read", 32'(s_rd), 32'(tbl[i].rd));
      chk("t1_valid", 32'(s_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) chk("t1_data", 32'(s_data), 32'(tbl[i].data));
      chk("t1_beat", 32'(s_beat4), 32'(tbl[i].beat));
      chk("t1_last", 32'(s_last4), 32'(tbl[i].last));
    end

    // Test 2: 20 words, o_ready pattern 1,0,0,1
    do_reset();
    next_word = 16'h0101;
    for (int c = 0; c < 300 && delivered < 20; c++)
      cycle(((c % 4) == 0) || ((c % 4) == 3), (c == 0) ? 20 : 0, 1'b0);
    chk("t2_delivered", 32'(delivered), 32'd20);
    cycle(1'b1, 0, 1'b0);
    chk("t2_idle_valid", 32'(s_valid), 32'd0);
    chk("t2_left", 32'(exp_q.size()), 32'd0);

    // Test 3: PKTLEN=4 packet boundaries
    do_reset();
    next_word = 16'h0301;
    cycle(1'b1, 10, 1'b0);
    run_until(10, 100);
    cycle(1'b1, 0, 1'b0);
    chk("t3_mask10", 32'(last_mask4), 32'h0088);
    chk("t3_beat_end", 32'(s_beat4), 32'd2);
    cycle(1'b1, 2, 1'b0);
    run_until(12, 100);
    chk("t3_mask12", 32'(last_mask4), 32'h0888);

    // Test 4: FIFO gap mid-packet, PKTLEN=8
    do_reset();
    next_word = 16'h0401;
    cycle(1'b1, 5, 1'b0);
    run_until(5, 100);
    repeat (10) cycle(1'b1, 0, 1'b0);
    chk("t4_gap_beat", 32'(s_beat8), 32'd5);
    chk("t4_gap_valid", 32'(s_valid), 32'd0);
    cycle(1'b1, 10, 1'b0);
    run_until(15, 200);
    repeat (4) cycle(1'b1, 0, 1'b0);
    chk("t4_mask8", 32'(last_mask8), 32'h0080);
    chk("t4_beat_end", 32'(s_beat8), 32'd7);
    chk("t4_left", 32'(exp_q.size()), 32'd0);

    // Test 5: reset while 3 words are buffered or in flight
    do_reset();
    next_word = 16'h0501;
    cycle(1'b1, 2, 1'b0);
    run_until(2, 50);
    cycle(1'b1, 0, 1'b0);
    chk("t5_pre_beat", 32'(s_beat4), 32'd2);
    cycle(1'b0, 6, 1'b0);
    cycle(1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 0, 1'b0);
    chk("t5_valid", 32'(s_valid), 32'd0);
    chk("t5_beat4", 32'(s_beat4), 32'd0);
    chk("t5_beat8", 32'(s_beat8), 32'd0);
    chk("t5_read", 32'(s_rd), 32'd0);
    next_word = 16'h05A0;
    cycle(1'b0, 3, 1'b0);
    for (int c = 0; c < 10 && !s_valid; c++) cycle(1'b0, 0, 1'b0);
    chk("t5_first_valid", 32'(s_valid), 32'd1);
    chk("t5_first_data", 32'(s_data), 32'h05A0);
    chk("t5_first_beat", 32'(s_beat4), 32'd0);
    run_until(3, 50);

`ifdef FIFO_STREAM_RD_STATS_EN
    // Test 6: stall and starve counters
    do_reset();
    next_word = 16'h0601;
    cycle(1'b0, 3, 1'b0);
    repeat (9) cycle(1'b0, 0, 1'b0);
    cycle(1'b1, 0, 1'b0);
    chk("t6_stall", s_stall4, 32'd7);
    chk("t6_starve0", s_starve4, 32'd0);
    cycle(1'b1, 0, 1'b0);
    cycle(1'b1, 0, 1'b0);
    chk("t6_delivered", 32'(delivered), 32'd3);
    cycle(1'b1, 0, 1'b0);
    cycle(1'b1, 1, 1'b0);
    cycle(1'b1, 0, 1'b0);
    cycle(1'b1, 0, 1'b0);
    cycle(1'b1, 0, 1'b0);
    chk("t6_valid", 32'(s_valid), 32'd1);
    chk("t6_starve4", s_starve4, 32'd4);
    chk("t6_starve1", s_starve1, 32'd0);
    chk("t6_stall_keep", s_stall4, 32'd7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
